ext_mem_responder: RTL and testbench
====================================

# ext_mem_responder

Synthesizable dual-channel external-memory slave that sits directly downstream of the HLS-generated `main` accelerator's master memory port (`Mout_*`). It answers channel reads and writes with fixed, parameterised latency, merges the accelerator's own slave read-back (`Sout_*`) into the returned bus, and provides a side-load port so the memory contents can be preloaded before `start_port`. It replaces the behavioural memory model used in simulation, so the same latency contract can run on FPGA.

## Interface
- `BASE_ADDR`, 0: first byte address served.
- `MEM_BYTES`, 32: bytes of storage (1..128).
- `ADDR_W`, 7: per-channel address width.
- `READ_LAT`, 2: cycles from first `oe` cycle to `M_DataRdy` inclusive (>=2).
- `WRITE_LAT`, 1: cycles from first `we` cycle to `M_DataRdy` inclusive (>=1).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `Mout_oe_ram`  in  2  per-channel read request.
- `Mout_we_ram`  in  2  per-channel write request.
- `Mout_addr_ram`  in  2*ADDR_W  channel c at `[c*ADDR_W +: ADDR_W]`.
- `Mout_Wdata_ram`  in  16  channel c at `[c*8 +: 8]`.
- `Mout_data_ram_size`  in  8  channel c bit count at `[c*4 +: 4]`.
- `Sout_Rdata_ram`  in  16  accelerator slave read data, ORed into the output.
- `Sout_DataRdy`  in  2  accelerator slave ready, ORed into the output.
- `load_we`  in  1  preload strobe.
- `load_addr`  in  ADDR_W  preload byte address, absolute.
- `load_data`  in  8  preload byte.
- `M_Rdata_ram`  out  16  read data to the master.
- `M_DataRdy`  out  2  per-channel completion.
- `err_conflict`  out  1  sticky: `oe` and `we` seen together on one channel.

## Operation
- Window hit for channel c: `BASE_ADDR <= addr_c < BASE_ADDR+MEM_BYTES`. Offset is `addr_c - BASE_ADDR`.
- Requests outside the window are ignored. The outputs then carry only the `Sout_*` terms.
- Each channel has a latency counter `cnt_c`:
  - It increments each cycle while a hit request is held and not yet ready.
  - It clears to 0 on the ready cycle, or when no hit request is present.
- Ready condition: `M_DataRdy[c] = Sout_DataRdy[c] | hit_c & ((oe_c & cnt_c==READ_LAT-1) | (we_c & cnt_c==WRITE_LAT-1))`.
- The master holds the request until it sees ready. Dropping a request early aborts it: the counter clears, nothing is written, and no ready is issued.
- Read path:
  - The byte at the offset is sampled every cycle into a (READ_LAT-1)-deep pipeline.
  - `M_Rdata_ram[c]` = pipeline head OR `Sout_Rdata_ram[c]`. Non-hit cycles push 0.
- Write path:
  - Mask = `(1<<size)-1` truncated to 8 bits; size >= 8 gives `0xFF`, size 0 gives no change.
  - The committed byte is `(wdata & mask) | (old & ~mask)`, written at the clock edge ending the ready cycle.
- Same-edge collisions:
  - Priority, highest first: channel 1, then channel 0, then `load_we`.
  - Loads to a different byte proceed in the same cycle.
  - A `load_addr` outside the window is dropped.
- Reads see the memory state from before same-edge writes; there is no bypass.
- `oe` and `we` on the same channel: `err_conflict` sets (sticky until reset), the request is ignored, and the counter holds at 0.
- Reset: storage, counters, read pipelines and `err_conflict` all clear to 0. `M_DataRdy` and `M_Rdata_ram` then equal their `Sout_*` inputs. A request pending at reset is discarded.

## Timing
- Read: `oe` first seen in cycle t, ready in cycle t+READ_LAT-1, with data valid in that same cycle.
- Write: ready in cycle t+WRITE_LAT-1. With WRITE_LAT=1, ready is combinational in cycle t.
- Back-to-back: a new request may start the cycle after ready; the counter is already 0.
- Combinational paths `Sout_*` to `M_*` and `Mout_*` to `M_DataRdy` are intentional; the master registers them.

## Structure
- Package `ext_mem_pkg` holds:
  - `CHANNELS=2`, `BYTE_W=8`, `SIZE_W=4`;
  - function `size_to_mask`;
  - typedef `chan_req_t` (oe, we, addr, wdata, size).
- Sub-module `ext_mem_channel_ctrl`, instantiated twice: window check, counter, ready generation, read pipeline, conflict detect.
- The top level owns the byte array, the write arbitration and the load port.

## Test plan
- Preload via `load_*` 0x05=0xA5, then ch0 read 0x05 held → `M_DataRdy[0]`=1 exactly one cycle later, `M_Rdata_ram[7:0]`=0xA5.
- Ch1 write 0x03 data 0xFF size 4 over old 0x12 → ready in the same cycle; a following read returns 0x1F.
- Both channels write 0x07 on the same edge (0x11 on ch0, 0x22 on ch1) → 0x22 stored.
- Ch0 `oe`=`we`=1 at 0x01 → `err_conflict`=1 and stays 1; no ready; memory unchanged; reset clears the flag.
- Read at 0x40 with MEM_BYTES=32 → no ready. `Sout_DataRdy[0]`=1 with `Sout_Rdata_ram`=0x3C → outputs ready and 0x3C.
- Reset asserted mid-read (cycle t) → no ready at t+1; all bytes read back 0 afterward.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the external-memory responder slice.
package ext_mem_pkg;

  localparam int CHANNELS   = 2;
  localparam int BYTE_W     = 8;
  localparam int SIZE_W     = 4;
  localparam int ADDR_MAX_W = 16;
  localparam int OFF_W      = 7;

  typedef struct packed {
    logic                  oe;
    logic                  we;
    logic [ADDR_MAX_W-1:0] addr;
    logic [BYTE_W-1:0]     wdata;
    logic [SIZE_W-1:0]     size;
  } chan_req_t;

  // Bit count to byte-lane mask; 0 bits leaves the byte untouched.
  function automatic logic [BYTE_W-1:0] size_to_mask(input logic [SIZE_W-1:0] size);
    if (size >= SIZE_W'(BYTE_W)) return '1;
    return BYTE_W'((32'd1 << size) - 32'd1);
  endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// Master-port bus between the accelerator and the external-memory responder.
interface ext_mem_responder_if #(
  parameter int ADDR_W = 7
);
  import ext_mem_pkg::*;

  logic [CHANNELS-1:0]        Mout_oe_ram;
  logic [CHANNELS-1:0]        Mout_we_ram;
  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
  logic [CHANNELS*BYTE_W-1:0] Mout_Wdata_ram;
  logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
  logic [CHANNELS*BYTE_W-1:0] Sout_Rdata_ram;
  logic [CHANNELS-1:0]        Sout_DataRdy;
  logic [CHANNELS*BYTE_W-1:0] M_Rdata_ram;
  logic [CHANNELS-1:0]        M_DataRdy;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy,
    input  M_Rdata_ram, M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  Sout_Rdata_ram, Sout_DataRdy,
    output M_Rdata_ram, M_DataRdy
  );

endinterface

// File: rtl/ext_mem_channel_ctrl.sv
// Per-channel window decode, latency counter, ready generation and read-data pipeline.
module ext_mem_channel_ctrl
  import ext_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEM_BYTES = 32,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  chan_req_t         req,
  input  logic [BYTE_W-1:0] mem_byte,
  input  logic              sout_rdy,
  input  logic [BYTE_W-1:0] sout_rdata,
  output logic [OFF_W-1:0]  offset,
  output logic              wr_en,
  output logic [BYTE_W-1:0] wr_byte,
  output logic              data_rdy,
  output logic [BYTE_W-1:0] rdata,
  output logic              conflict
);

  localparam int         PIPE_D  = READ_LAT - 1;
  localparam logic [7:0] RD_LAST = 8'(READ_LAT - 1);
  localparam logic [7:0] WR_LAST = 8'(WRITE_LAT - 1);

  logic [31:0]       addr_ext;
  logic              in_win;
  logic              hit;
  logic              clash;
  logic              act;
  logic              rdy_int;
  logic [BYTE_W-1:0] mask;
  logic [7:0]        cnt;
  logic [BYTE_W-1:0] rd_p [PIPE_D];

  always_comb begin
    addr_ext = 32'(req.addr);
    in_win   = (addr_ext >= BASE_ADDR) && (addr_ext < BASE_ADDR + MEM_BYTES);
    offset   = OFF_W'(addr_ext - BASE_ADDR);
    hit      = in_win & (req.oe | req.we);
    clash    = req.oe & req.we;
    // A conflicting request never counts, so the counter parks at 0.
    act      = hit & ~clash;
    rdy_int  = act & ((req.oe & (cnt == RD_LAST)) | (req.we & (cnt == WR_LAST)));
    mask     = size_to_mask(req.size);
    wr_en    = rdy_int & req.we;
    wr_byte  = (req.wdata & mask) | (mem_byte & ~mask);
    data_rdy = sout_rdy | rdy_int;
    rdata    = rd_p[PIPE_D-1] | sout_rdata;
  end

  // Stage boundary: counter, sticky conflict flag and read pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      conflict <= 1'b0;
      for (int i = 0; i < PIPE_D; i++) rd_p[i] <= '0;
    end else begin
      if (!act || rdy_int) cnt <= '0;
      else                 cnt <= cnt + 8'd1;
      if (clash) conflict <= 1'b1;
      rd_p[0] <= hit ? mem_byte : '0;
      for (int i = 1; i < PIPE_D; i++) rd_p[i] <= rd_p[i-1];
    end
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Dual-channel fixed-latency memory slave with preload port, downstream of the accelerator master port.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEM_BYTES = 32,
  parameter int          ADDR_W    = 7,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  ext_mem_responder_if.slave         bus,
  input  logic                       load_we,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [BYTE_W-1:0]          load_data,
  output logic                       err_conflict
);

  logic [BYTE_W-1:0]                 mem [1<<OFF_W];
  logic [CHANNELS-1:0][OFF_W-1:0]    off;
  logic [CHANNELS-1:0]               wr_en;
  logic [CHANNELS-1:0][BYTE_W-1:0]   wr_byte;
  logic [CHANNELS-1:0][BYTE_W-1:0]   mem_byte;
  logic [CHANNELS-1:0][BYTE_W-1:0]   rdata_c;
  logic [CHANNELS-1:0]               rdy_c;
  logic [CHANNELS-1:0]               conflict_c;
  logic [31:0]                       load_ext;
  logic                              load_hit;
  logic [OFF_W-1:0]                  load_off;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    chan_req_t req;

    assign req = '{oe:    bus.Mout_oe_ram[c],
                   we:    bus.Mout_we_ram[c],
                   addr:  ADDR_MAX_W'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]),
                   wdata: bus.Mout_Wdata_ram[c*BYTE_W +: BYTE_W],
                   size:  bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W]};
    assign mem_byte[c] = mem[off[c]];

    ext_mem_channel_ctrl #(
      .BASE_ADDR (BASE_ADDR),
      .MEM_BYTES (MEM_BYTES),
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT)
    ) u_ctrl (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .mem_byte   (mem_byte[c]),
      .sout_rdy   (bus.Sout_DataRdy[c]),
      .sout_rdata (bus.Sout_Rdata_ram[c*BYTE_W +: BYTE_W]),
      .offset     (off[c]),
      .wr_en      (wr_en[c]),
      .wr_byte    (wr_byte[c]),
      .data_rdy   (rdy_c[c]),
      .rdata      (rdata_c[c]),
      .conflict   (conflict_c[c])
    );
  end

  assign bus.M_DataRdy   = rdy_c;
  assign bus.M_Rdata_ram = rdata_c;
  assign err_conflict    = |conflict_c;

  always_comb begin
    load_ext = 32'(load_addr);
    load_hit = (load_ext >= BASE_ADDR) && (load_ext < BASE_ADDR + MEM_BYTES);
    load_off = OFF_W'(load_ext - BASE_ADDR);
  end

  // Stage boundary: byte array; later assignments win, so channel 1 beats channel 0 beats the load port.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < (1 << OFF_W); i++) mem[i] <= '0;
    end else begin
      if (load_we && load_hit) mem[load_off] <= load_data;
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en[c]) mem[off[c]] <= wr_byte[c];
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: preload, read/write latency, collisions, conflict, window and reset.
module tb_ext_mem_responder;

  logic       clock;
  logic       reset;
  logic       load_we;
  logic [6:0] load_addr;
  logic [7:0] load_data;
  logic       err_conflict;
  int         checks;
  int         errors;

  ext_mem_responder_if #(.ADDR_W(7)) bus ();

  ext_mem_responder #(
    .BASE_ADDR (0),
    .MEM_BYTES (32),
    .ADDR_W    (7),
    .READ_LAT  (2),
    .WRITE_LAT (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .load_we      (load_we),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .err_conflict (err_conflict)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus.Mout_oe_ram        = '0;
    bus.Mout_we_ram        = '0;
    bus.Mout_addr_ram      = '0;
    bus.Mout_Wdata_ram     = '0;
    bus.Mout_data_ram_size = '0;
    bus.Sout_Rdata_ram     = '0;
    bus.Sout_DataRdy       = '0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_byte(input logic [6:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_we   = 1'b1;
    tick();
    load_we   = 1'b0;
  endtask

  // Channel-0 read held through its ready cycle; returns data and ready seen in cycle t+1.
  task automatic rd0(input logic [6:0] a, output logic [7:0] d, output logic r);
    bus.Mout_addr_ram[6:0] = a;
    bus.Mout_oe_ram[0]     = 1'b1;
    tick();
    @(negedge clock);
    d = bus.M_Rdata_ram[7:0];
    r = bus.M_DataRdy[0];
    tick();
    bus.Mout_oe_ram[0] = 1'b0;
  endtask

  task automatic set_wr(input int ch, input logic [6:0] a, input logic [7:0] d, input logic [3:0] sz);
    bus.Mout_addr_ram[ch*7 +: 7]      = a;
    bus.Mout_Wdata_ram[ch*8 +: 8]     = d;
    bus.Mout_data_ram_size[ch*4 +: 4] = sz;
    bus.Mout_we_ram[ch]               = 1'b1;
  endtask

  task automatic test_reset();
    idle_bus();
    do_reset();
    @(negedge clock);
    checks++;
    if (bus.M_DataRdy !== 2'b00) begin
      errors++; $display("FAIL reset_rdy: got %b expected 00", bus.M_DataRdy);
    end
    checks++;
    if (bus.M_Rdata_ram !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0000", bus.M_Rdata_ram);
    end
    checks++;
    if (err_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", err_conflict);
    end
    tick();
  endtask

  task automatic test_read();
    logic [7:0] d;
    load_byte(7'h05, 8'hA5);
    bus.Mout_addr_ram[6:0] = 7'h05;
    bus.Mout_oe_ram[0]     = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.M_DataRdy !== 2'b00) begin
      errors++; $display("FAIL read_early_rdy: got %b expected 00", bus.M_DataRdy);
    end
    tick();
    @(negedge clock);
    d = bus.M_Rdata_ram[7:0];
    checks++;
    if (bus.M_DataRdy !== 2'b01) begin
      errors++; $display("FAIL read_rdy: got %b expected 01", bus.M_DataRdy);
    end
    checks++;
    if (d !== 8'hA5) begin
      errors++; $display("FAIL read_data: got %h expected a5", d);
    end
    tick();
    bus.Mout_oe_ram[0] = 1'b0;
  endtask

  task automatic test_write();
    logic [7:0] d;
    logic       r;
    load_byte(7'h03, 8'h12);
    set_wr(1, 7'h03, 8'hFF, 4'd4);
    @(negedge clock);
    checks++;
    if (bus.M_DataRdy !== 2'b10) begin
      errors++; $display("FAIL write_rdy: got %b expected 10", bus.M_DataRdy);
    end
    tick();
    bus.Mout_we_ram = '0;
    rd0(7'h03, d, r);
    checks++;
    if (d !== 8'h1F || r !== 1'b1) begin
      errors++; $display("FAIL write_merge: got %h/%b expected 1f/1", d, r);
    end
    set_wr(0, 7'h03, 8'h00, 4'd0);
    tick();
    bus.Mout_we_ram = '0;
    set_wr(0, 7'h04, 8'hC3, 4'd12);
    tick();
    bus.Mout_we_ram = '0;
    rd0(7'h03, d, r);
    checks++;
    if (d !== 8'h1F) begin
      errors++; $display("FAIL write_size0: got %h expected 1f", d);
    end
    rd0(7'h04, d, r);
    checks++;
    if (d !== 8'hC3) begin
      errors++; $display("FAIL write_size12: got %h expected c3", d);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    logic       r;
    set_wr(0, 7'h07, 8'h11, 4'd8);
    set_wr(1, 7'h07, 8'h22, 4'd8);
    load_addr = 7'h08;
    load_data = 8'h44;
    load_we   = 1'b1;
    tick();
    bus.Mout_we_ram = '0;
    set_wr(0, 7'h09, 8'h55, 4'd8);
    load_addr = 7'h09;
    load_data = 8'h66;
    tick();
    bus.Mout_we_ram = '0;
    load_addr = 7'h50;
    load_data = 8'h77;
    tick();
    load_we = 1'b0;
    rd0(7'h07, d, r);
    checks++;
    if (d !== 8'h22) begin
      errors++; $display("FAIL coll_ch1_wins: got %h expected 22", d);
    end
    rd0(7'h08, d, r);
    checks++;
    if (d !== 8'h44) begin
      errors++; $display("FAIL coll_load_other: got %h expected 44", d);
    end
    rd0(7'h09, d, r);
    checks++;
    if (d !== 8'h55) begin
      errors++; $display("FAIL coll_ch0_over_load: got %h expected 55", d);
    end
    rd0(7'h10, d, r);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL coll_load_outside: got %h expected 00", d);
    end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    logic       r;
    load_byte(7'h01, 8'h3A);
    bus.Mout_addr_ram[6:0] = 7'h01;
    bus.Mout_Wdata_ram[7:0] = 8'hEE;
    bus.Mout_data_ram_size[3:0] = 4'd8;
    bus.Mout_oe_ram[0] = 1'b1;
    bus.Mout_we_ram[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus.M_DataRdy[0] !== 1'b0) begin
        errors++; $display("FAIL conflict_no_rdy[%0d]: got %b expected 0", i, bus.M_DataRdy[0]);
      end
      tick();
    end
    bus.Mout_oe_ram = '0;
    bus.Mout_we_ram = '0;
    tick();
    @(negedge clock);
    checks++;
    if (err_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_sticky: got %b expected 1", err_conflict);
    end
    tick();
    rd0(7'h01, d, r);
    checks++;
    if (d !== 8'h3A) begin
      errors++; $display("FAIL conflict_mem: got %h expected 3a", d);
    end
    do_reset();
    @(negedge clock);
    checks++;
    if (err_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_clear: got %b expected 0", err_conflict);
    end
    tick();
  endtask

  task automatic test_outside();
    bus.Mout_addr_ram[6:0] = 7'h40;
    bus.Mout_oe_ram[0]     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus.M_DataRdy !== 2'b00 || bus.M_Rdata_ram !== 16'h0000) begin
        errors++; $display("FAIL outside_ignored[%0d]: got %b/%h expected 00/0000", i, bus.M_DataRdy, bus.M_Rdata_ram);
      end
      tick();
    end
    bus.Sout_DataRdy   = 2'b01;
    bus.Sout_Rdata_ram = 16'h003C;
    @(negedge clock);
    checks++;
    if (bus.M_DataRdy !== 2'b01 || bus.M_Rdata_ram !== 16'h003C) begin
      errors++; $display("FAIL outside_sout: got %b/%h expected 01/003c", bus.M_DataRdy, bus.M_Rdata_ram);
    end
    tick();
    bus.Mout_oe_ram    = '0;
    bus.Sout_DataRdy   = '0;
    bus.Sout_Rdata_ram = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    set_wr(0, 7'h0A, 8'h5C, 4'd8);
    tick();
    bus.Mout_we_ram    = '0;
    bus.Mout_oe_ram[0] = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.M_DataRdy[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_first_cycle: got %b expected 0", bus.M_DataRdy[0]);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.M_DataRdy[0] !== 1'b1 || bus.M_Rdata_ram[7:0] !== 8'h5C) begin
      errors++; $display("FAIL b2b_read: got %b/%h expected 1/5c", bus.M_DataRdy[0], bus.M_Rdata_ram[7:0]);
    end
    tick();
    bus.Mout_oe_ram = '0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    logic       r;
    load_byte(7'h04, 8'h99);
    bus.Mout_addr_ram[6:0] = 7'h04;
    bus.Mout_oe_ram[0]     = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.M_DataRdy[0] !== 1'b0 || bus.M_Rdata_ram[7:0] !== 8'h00) begin
      errors++; $display("FAIL midreset_no_rdy: got %b/%h expected 0/00", bus.M_DataRdy[0], bus.M_Rdata_ram[7:0]);
    end
    tick();
    bus.Mout_oe_ram = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [6:0] a;
      a = 7'(i * 3 + 4);
      rd0(a, d, r);
      checks++;
      if (d !== 8'h00 || r !== 1'b1) begin
        errors++; $display("FAIL midreset_cleared[%h]: got %h/%b expected 00/1", a, d, r);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_bus();
    test_reset();
    test_read();
    test_write();
    test_collision();
    test_conflict();
    test_outside();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
